burst_sram_ctrl: RTL

Parametrised burst memory controller that accepts a single command (address, length, burst type, direction) and then moves one data beat per cycle between ready/valid streams and an internal single-port SRAM. Address sequencing is internal: FIXED, INCR and WRAP bursts are generated without per-beat addresses from the host. It sits between a bus-side master (DMA or test driver) and the local memory, replacing the per-beat address path with burst-aware sequencing and backpressure.

---
 rtl/burst_sram_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/burst_sram_ctrl.sv
// burst_sram_ctrl: single-command burst sequencer (FIXED/INCR/WRAP) in front of a single-port SRAM.
// Define BURST_CTRL_WRAP_EN to enable WRAP sequencing; otherwise WRAP is handled like the reserved encoding.
module burst_sram_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic [1:0]            cmd_burst,
    output logic                  cmd_err,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
    typedef enum logic [1:0] {B_FIXED, B_INCR, B_WRAP} mode_t;

    state_t                state;
    mode_t                 mode;
    mode_t                 cmd_mode;
    logic                  cmd_illegal;
    logic                  wrap_ok;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [LEN_WIDTH-1:0]  len;
    logic [LEN_WIDTH:0]    cnt;
    logic                  cmd_fire;
    logic                  wr_fire;
    logic                  last_beat;
    logic                  issue;
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    assign cmd_fire  = cmd_valid && cmd_ready;
    assign wr_fire   = wr_valid && wr_ready;
    assign last_beat = (cnt == {1'b0, len});
    assign issue     = (cnt <= {1'b0, len}) && (!rd_valid || rd_ready);

`ifdef BURST_CTRL_WRAP_EN
    logic [LEN_WIDTH:0]    len_p1;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    // Legal WRAP needs a power-of-two beat count of at least two.
    assign len_p1    = {1'b0, cmd_len} + 1'b1;
    assign wrap_ok   = (cmd_len != '0) && ((len_p1 & {1'b0, cmd_len}) == '0);
    assign wrap_mask = ADDR_WIDTH'(len);
`else
    assign wrap_ok = 1'b0;
`endif

    always_comb begin
        cmd_mode    = B_INCR;
        cmd_illegal = 1'b0;
        case (cmd_burst)
            2'd0:    cmd_mode = B_FIXED;
            2'd1:    cmd_mode = B_INCR;
            2'd2: begin
                if (wrap_ok) cmd_mode = B_WRAP;
                else         cmd_illegal = 1'b1;
            end
            default: cmd_illegal = 1'b1;
        endcase
    end

    always_comb begin
        next_addr = cur_addr;
        case (mode)
            B_INCR:  next_addr = cur_addr + ADDR_WIDTH'(1);
`ifdef BURST_CTRL_WRAP_EN
            B_WRAP:  next_addr = (cur_addr & ~wrap_mask) | ((cur_addr + ADDR_WIDTH'(1)) & wrap_mask);
`endif
            default: next_addr = cur_addr;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem[cur_addr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mode      <= B_INCR;
            cur_addr  <= '0;
            len       <= '0;
            cnt       <= '0;
            cmd_ready <= 1'b1;
            cmd_err   <= 1'b0;
            wr_ready  <= 1'b0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            rd_data   <= '0;
            busy      <= 1'b0;
        end else begin
            cmd_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_fire) begin
                        cur_addr  <= cmd_addr;
                        len       <= cmd_len;
                        mode      <= cmd_mode;
                        cnt       <= '0;
                        cmd_err   <= cmd_illegal;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (cmd_write) begin
                            state    <= WRITE;
                            wr_ready <= 1'b1;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                WRITE: begin
                    if (wr_fire) begin
                        cur_addr <= next_addr;
                        cnt      <= cnt + 1'b1;
                        if (last_beat) begin
                            state     <= IDLE;
                            wr_ready  <= 1'b0;
                            cmd_ready <= 1'b1;
                            busy      <= 1'b0;
                        end
                    end
                end
                READ: begin
                    // A one-deep output register: refill only when empty or being drained.
                    if (rd_valid && rd_ready && rd_last) begin
                        rd_valid  <= 1'b0;
                        rd_last   <= 1'b0;
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else if (issue) begin
                        rd_data  <= mem[cur_addr];
                        rd_valid <= 1'b1;
                        rd_last  <= last_beat;
                        cur_addr <= next_addr;
                        cnt      <= cnt + 1'b1;
                    end else if (rd_ready) begin
                        rd_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
